// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults for the register file / busy scoreboard slice.
package regfile_scoreboard_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int ZERO_IDX  = 0;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback/issue-side signal bundle of the register file.
interface regfile_scoreboard_if
    import regfile_scoreboard_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = $clog2(DEF_DEPTH)
);
    logic              ctrl_writeEnable;
    logic [ADDR_W-1:0] ctrl_writeReg;
    logic [WIDTH-1:0]  data_writeReg;
    logic [ADDR_W-1:0] ctrl_readRegA;
    logic [ADDR_W-1:0] ctrl_readRegB;
    logic [WIDTH-1:0]  data_readRegA;
    logic [WIDTH-1:0]  data_readRegB;
    logic              ctrl_reserve;
    logic [ADDR_W-1:0] ctrl_reserveReg;
    logic              busy_A;
    logic              busy_B;
    logic [ADDR_W:0]   pending_count;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output ctrl_readRegA, ctrl_readRegB, ctrl_reserve, ctrl_reserveReg,
        input  data_readRegA, data_readRegB, busy_A, busy_B, pending_count
    );
    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  ctrl_readRegA, ctrl_readRegB, ctrl_reserve, ctrl_reserveReg,
        output data_readRegA, data_readRegB, busy_A, busy_B, pending_count
    );
endinterface

// File: rtl/regfile_scoreboard_register_param.sv
// One storage entry: WIDTH-bit register with load enable and async clear.
module register_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q, q_d;

    always_comb q_d = en ? d : q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write bypass and a per-register busy scoreboard that
// long-latency units reserve at issue and writeback releases.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  regs [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   pending_count_q, pending_count_d;
    logic [ADDR_W-1:0] raddr [2];
    logic [WIDTH-1:0]  rdata [2];
    logic              rbusy [2];

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (ZERO_REG != 0 && i == ZERO_IDX) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_store
            logic en;
            assign en = bus.ctrl_writeEnable && (bus.ctrl_writeReg == ADDR_W'(i));
            register_param #(.WIDTH(WIDTH)) u_reg (
                .clk (clk),
                .rst (reset),
                .en  (en),
                .d   (bus.data_writeReg),
                .q   (regs[i])
            );
        end
    end

    function automatic logic [ADDR_W:0] popcnt(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) c = c + {{ADDR_W{1'b0}}, v[i]};
        return c;
    endfunction

    // Reservation is applied after release so a same-index reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (bus.ctrl_writeEnable) busy_d[bus.ctrl_writeReg] = 1'b0;
        if (bus.ctrl_reserve)     busy_d[bus.ctrl_reserveReg] = 1'b1;
        if (ZERO_REG != 0)        busy_d[ZERO_IDX] = 1'b0;
        pending_count_d = popcnt(busy_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q          <= '0;
            pending_count_q <= '0;
        end else begin
            busy_q          <= busy_d;
            pending_count_q <= pending_count_d;
        end
    end

    assign raddr[0] = bus.ctrl_readRegA;
    assign raddr[1] = bus.ctrl_readRegB;

    // Bypass is suppressed while reset is held so reads stay at zero.
    always_comb begin
        logic is_zero, hit;
        for (int p = 0; p < 2; p++) begin
            is_zero  = (ZERO_REG != 0) && (raddr[p] == ADDR_W'(ZERO_IDX));
            hit      = (BYPASS != 0) && !reset && bus.ctrl_writeEnable &&
                       (bus.ctrl_writeReg == raddr[p]);
            rdata[p] = regs[raddr[p]];
            rbusy[p] = busy_q[raddr[p]];
            if (is_zero) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end else if (hit) begin
                rdata[p] = bus.data_writeReg;
                if (!(bus.ctrl_reserve && bus.ctrl_reserveReg == raddr[p])) rbusy[p] = 1'b0;
            end
        end
    end

    assign bus.data_readRegA = rdata[0];
    assign bus.data_readRegB = rdata[1];
    assign bus.busy_A        = rbusy[0];
    assign bus.busy_B        = rbusy[1];
    assign bus.pending_count = pending_count_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: expectations queued at drive time, drained and compared
// against the BYPASS=1 and BYPASS=0 instances.
module tb_regfile_scoreboard;
    localparam int W = 32;
    localparam int D = 32;
    localparam int AW = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    regfile_scoreboard_if #(.WIDTH(W), .ADDR_W(AW)) bus ();
    regfile_scoreboard_if #(.WIDTH(W), .ADDR_W(AW)) bus0 ();

    regfile_scoreboard #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    regfile_scoreboard #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));

    assign bus0.ctrl_writeEnable = bus.ctrl_writeEnable;
    assign bus0.ctrl_writeReg    = bus.ctrl_writeReg;
    assign bus0.data_writeReg    = bus.data_writeReg;
    assign bus0.ctrl_readRegA    = bus.ctrl_readRegA;
    assign bus0.ctrl_readRegB    = bus.ctrl_readRegB;
    assign bus0.ctrl_reserve     = bus.ctrl_reserve;
    assign bus0.ctrl_reserveReg  = bus.ctrl_reserveReg;

    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            0:       return bus.data_readRegA;
            1:       return bus.data_readRegB;
            2:       return {31'd0, bus.busy_A};
            3:       return {31'd0, bus.busy_B};
            4:       return {26'd0, bus.pending_count};
            default: return bus0.data_readRegB;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [31:0] v);
        sb.push_back('{tag, sel, v});
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = pick(e.sel);
            checks++;
            assert (obs === e.v) else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ctrl_writeEnable = 1'b0;
        bus.ctrl_reserve     = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.ctrl_writeEnable = 1'b0; bus.ctrl_writeReg = '0; bus.data_writeReg = '0;
        bus.ctrl_readRegA = 5'd3; bus.ctrl_readRegB = 5'd4;
        bus.ctrl_reserve = 1'b0; bus.ctrl_reserveReg = '0;
        tick(); tick();
        push_exp("rst_dataA", 0, 32'd0);
        push_exp("rst_busyA", 2, 32'd0);
        push_exp("rst_pend", 4, 32'd0);
        drain();
        reset = 1'b0;
        tick();

        // Fill every register and leave two reservations outstanding.
        for (int i = 1; i < D; i++) begin
            bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = AW'(i);
            bus.data_writeReg = 32'h111 * i;
            tick();
        end
        idle();
        bus.ctrl_reserve = 1'b1; bus.ctrl_reserveReg = 5'd20; tick();
        bus.ctrl_reserveReg = 5'd21; tick();
        idle();
        bus.ctrl_readRegA = 5'd12; bus.ctrl_readRegB = 5'd20; #1;
        push_exp("fill_dataA", 0, 32'h111 * 12);
        push_exp("fill_busyB", 3, 32'd1);
        push_exp("fill_pend", 4, 32'd2);
        drain();
        reset = 1'b1; #1;
        push_exp("midrst_dataA", 0, 32'd0);
        push_exp("midrst_busyB", 3, 32'd0);
        push_exp("midrst_pend", 4, 32'd0);
        drain();
        tick();
        reset = 1'b0;
        tick();

        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd5; bus.data_writeReg = 32'hDEADBEEF;
        tick();
        idle(); bus.ctrl_readRegA = 5'd5; #1;
        push_exp("wr5_dataA", 0, 32'hDEADBEEF);
        drain();

        // Register 0 ignores both writes and reservations.
        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd0; bus.data_writeReg = 32'hFFFFFFFF;
        bus.ctrl_reserve = 1'b1; bus.ctrl_reserveReg = 5'd0; bus.ctrl_readRegA = 5'd0; #1;
        push_exp("r0_comb_dataA", 0, 32'd0);
        push_exp("r0_comb_busyA", 2, 32'd0);
        drain();
        tick();
        idle(); #1;
        push_exp("r0_dataA", 0, 32'd0);
        push_exp("r0_busyA", 2, 32'd0);
        push_exp("r0_pend", 4, 32'd0);
        drain();

        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd7; bus.data_writeReg = 32'h1111;
        tick();
        bus.data_writeReg = 32'h12345678; bus.ctrl_readRegB = 5'd7; #1;
        push_exp("byp_dataB", 1, 32'h12345678);
        push_exp("nobyp_old_dataB", 5, 32'h1111);
        drain();
        tick();
        idle(); #1;
        push_exp("nobyp_new_dataB", 5, 32'h12345678);
        drain();

        bus.ctrl_reserve = 1'b1; bus.ctrl_reserveReg = 5'd9; bus.ctrl_readRegA = 5'd9;
        tick();
        idle(); #1;
        push_exp("res9_busyA", 2, 32'd1);
        push_exp("res9_pend", 4, 32'd1);
        drain();
        for (int i = 0; i < 4; i++) tick();
        push_exp("res9_hold_busyA", 2, 32'd1);
        drain();
        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd9; bus.data_writeReg = 32'd42; #1;
        push_exp("wb9_byp_busyA", 2, 32'd0);
        drain();
        tick();
        idle(); #1;
        push_exp("wb9_busyA", 2, 32'd0);
        push_exp("wb9_dataA", 0, 32'd42);
        push_exp("wb9_pend", 4, 32'd0);
        drain();

        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd3; bus.data_writeReg = 32'd7;
        bus.ctrl_reserve = 1'b1; bus.ctrl_reserveReg = 5'd3; bus.ctrl_readRegA = 5'd3;
        tick();
        idle(); #1;
        push_exp("same_dataA", 0, 32'd7);
        push_exp("same_busyA", 2, 32'd1);
        push_exp("same_pend", 4, 32'd1);
        drain();
        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd3; bus.data_writeReg = 32'd8;
        bus.ctrl_reserve = 1'b1; bus.ctrl_reserveReg = 5'd4; bus.ctrl_readRegB = 5'd4;
        tick();
        idle(); #1;
        push_exp("diff_busyA3", 2, 32'd0);
        push_exp("diff_busyB4", 3, 32'd1);
        push_exp("diff_pend", 4, 32'd1);
        drain();
        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd4; bus.data_writeReg = 32'd0;
        tick();
        idle(); #1;
        push_exp("clr4_pend", 4, 32'd0);
        drain();

        for (int i = 1; i < D; i++) begin
            bus.ctrl_reserve = 1'b1; bus.ctrl_reserveReg = AW'(i);
            tick();
        end
        idle(); bus.ctrl_readRegA = 5'd31; #1;
        push_exp("sat_pend", 4, 32'd31);
        push_exp("sat_busyA", 2, 32'd1);
        drain();
        bus.ctrl_reserve = 1'b1; bus.ctrl_reserveReg = 5'd10;
        tick();
        idle(); #1;
        push_exp("sat_rereserve_pend", 4, 32'd31);
        drain();
        reset = 1'b1; #1;
        push_exp("sat_rst_pend", 4, 32'd0);
        push_exp("sat_rst_busyA", 2, 32'd0);
        drain();
        tick();
        reset = 1'b0;
        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd10; bus.data_writeReg = 32'd5;
        tick();
        idle(); bus.ctrl_readRegA = 5'd10; #1;
        push_exp("late_wb_dataA", 0, 32'd5);
        push_exp("late_wb_pend", 4, 32'd0);
        push_exp("late_wb_busyA", 2, 32'd0);
        drain();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
